// File: rtl/dma_2d_desc_sched.sv
// Descriptor-queue scheduler for the DMA 2D read/write masters.
// Optional watchdog timeout and ERROR state: define DMA_SCHED_TIMEOUT_EN.
module dma_2d_desc_sched #(
    parameter int unsigned DESC_DEPTH = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT_W  = 24
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_enable,
    input  logic                          i_desc_valid,
    output logic                          o_desc_ready,
    input  logic [31:0]                   i_desc_src_addr,
    input  logic [31:0]                   i_desc_dst_addr,
    input  logic [31:0]                   i_desc_width,
    input  logic [31:0]                   i_desc_height,
    input  logic [31:0]                   i_desc_src_stride,
    input  logic [31:0]                   i_desc_dst_stride,
    input  logic                          i_desc_irq,
    output logic                          o_rd_start,
    output logic                          o_wr_start,
    output logic [31:0]                   o_rd_src_addr,
    output logic [31:0]                   o_rd_width,
    output logic [31:0]                   o_rd_height,
    output logic [31:0]                   o_rd_stride,
    output logic [31:0]                   o_wr_dst_addr,
    output logic [31:0]                   o_wr_width,
    output logic [31:0]                   o_wr_height,
    output logic [31:0]                   o_wr_stride,
    input  logic                          i_rd_done,
    input  logic                          i_wr_done,
    output logic                          o_busy,
    output logic [$clog2(DESC_DEPTH):0]   o_fifo_level,
    output logic [CNT_W-1:0]              o_done_count,
    output logic                          o_irq,
    input  logic                          i_irq_clr,
    output logic                          o_error,
    input  logic                          i_err_clr
);

    localparam int unsigned PTR_W = $clog2(DESC_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DESC_DEPTH);

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] width;
        logic [31:0] height;
        logic [31:0] src_stride;
        logic [31:0] dst_stride;
        logic        irq;
    } desc_t;

`ifdef DMA_SCHED_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_COMPLETE, S_ERROR} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_COMPLETE} state_e;
`endif

    state_e             state_q;
    desc_t              mem_q [DESC_DEPTH];
    desc_t              push_desc;
    desc_t              cur_q;
    desc_t              par_q;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               push, pop, flush;
    logic               rd_prev_q, wr_prev_q;
    logic               rd_edge, wr_edge;
    logic               rd_lat_q, wr_lat_q;
    logic               start_q;
    logic               irq_q;
    logic [CNT_W-1:0]   done_cnt_q;

    function automatic logic desc_invalid(input desc_t d);
        return (d.width == '0) || (d.height == '0) || (d.width[1:0] != 2'b00);
    endfunction

    assign push_desc = '{src:        i_desc_src_addr,
                         dst:        i_desc_dst_addr,
                         width:      i_desc_width,
                         height:     i_desc_height,
                         src_stride: i_desc_src_stride,
                         dst_stride: i_desc_dst_stride,
                         irq:        i_desc_irq};

    assign o_desc_ready = (level_q < DEPTH_L);
    assign push         = i_desc_valid && o_desc_ready;
    assign pop          = (state_q == S_IDLE) && i_enable && (level_q != '0);

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] wd_q;
    logic                 err_q;

    assign flush   = (state_q == S_ERROR) && i_err_clr;
    assign o_error = err_q;
`else
    localparam int unsigned unused_timeout_w = TIMEOUT_W;

    logic unused_err_clr;

    assign unused_err_clr = i_err_clr;
    assign flush          = 1'b0;
    assign o_error        = 1'b0;
`endif

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (pop && !push) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= push_desc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            rd_prev_q <= i_rd_done;
            wr_prev_q <= i_wr_done;
        end
    end

    assign rd_edge = i_rd_done && !rd_prev_q;
    assign wr_edge = i_wr_done && !wr_prev_q;

    // The popped entry is captured at the pop, since a push in the same
    // cycle may reuse the freed slot before LOAD copies it out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            par_q      <= '0;
            rd_lat_q   <= 1'b0;
            wr_lat_q   <= 1'b0;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
            done_cnt_q <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            if (i_irq_clr) irq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cur_q   <= mem_q[rptr_q];
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    par_q   <= cur_q;
                    state_q <= desc_invalid(cur_q) ? S_COMPLETE : S_START;
                end
                S_START: begin
                    start_q  <= 1'b1;
                    rd_lat_q <= 1'b0;
                    wr_lat_q <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
                    wd_q     <= '0;
`endif
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_edge) rd_lat_q <= 1'b1;
                    if (wr_edge) wr_lat_q <= 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
                    wd_q <= wd_q + TIMEOUT_W'(1);
                    if (rd_lat_q && wr_lat_q) begin
                        state_q <= S_COMPLETE;
                    end else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end
`else
                    if (rd_lat_q && wr_lat_q) state_q <= S_COMPLETE;
`endif
                end
                S_COMPLETE: begin
                    done_cnt_q <= done_cnt_q + CNT_W'(1);
                    if (par_q.irq) irq_q <= 1'b1;
                    state_q <= S_IDLE;
                end
`ifdef DMA_SCHED_TIMEOUT_EN
                S_ERROR: begin
                    if (i_err_clr) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_rd_start    = start_q;
    assign o_wr_start    = start_q;
    assign o_rd_src_addr = par_q.src;
    assign o_rd_width    = par_q.width;
    assign o_rd_height   = par_q.height;
    assign o_rd_stride   = par_q.src_stride;
    assign o_wr_dst_addr = par_q.dst;
    assign o_wr_width    = par_q.width;
    assign o_wr_height   = par_q.height;
    assign o_wr_stride   = par_q.dst_stride;
    assign o_busy        = (state_q != S_IDLE);
    assign o_fifo_level  = level_q;
    assign o_done_count  = done_cnt_q;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_dma_2d_desc_sched.sv
// Self-checking bench for dma_2d_desc_sched with a done-flag master model and start-pulse scoreboard.
// The watchdog scenario follows DMA_SCHED_TIMEOUT_EN (TIMEOUT_W=8 when defined).
module tb_dma_2d_desc_sched;

    localparam int unsigned DEPTH = 4;
`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int unsigned TW = 8;
`else
    localparam int unsigned TW = 24;
`endif

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] w;
        logic [31:0] h;
        logic [31:0] ss;
        logic [31:0] ds;
        logic        irq;
    } tdesc_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_enable, i_desc_valid, o_desc_ready;
    logic [31:0] i_desc_src_addr, i_desc_dst_addr, i_desc_width, i_desc_height;
    logic [31:0] i_desc_src_stride, i_desc_dst_stride;
    logic        i_desc_irq;
    logic        o_rd_start, o_wr_start;
    logic [31:0] o_rd_src_addr, o_rd_width, o_rd_height, o_rd_stride;
    logic [31:0] o_wr_dst_addr, o_wr_width, o_wr_height, o_wr_stride;
    logic        i_rd_done, i_wr_done;
    logic        o_busy;
    logic [2:0]  o_fifo_level;
    logic [15:0] o_done_count;
    logic        o_irq, i_irq_clr, o_error, i_err_clr;

    int          n_cmp = 0;
    int          n_err = 0;
    tdesc_t      sb_q[$];
    tdesc_t      mon_e;
    logic [15:0] exp_cnt = '0;
    int          rd_delay = 5, wr_delay = 5;
    int          rd_timer = 0, wr_timer = 0;
    bit          rd_hold = 1'b0;

    always #5 clk = ~clk;

    dma_2d_desc_sched #(
        .DESC_DEPTH (DEPTH),
        .CNT_W      (16),
        .TIMEOUT_W  (TW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_enable          (i_enable),
        .i_desc_valid      (i_desc_valid),
        .o_desc_ready      (o_desc_ready),
        .i_desc_src_addr   (i_desc_src_addr),
        .i_desc_dst_addr   (i_desc_dst_addr),
        .i_desc_width      (i_desc_width),
        .i_desc_height     (i_desc_height),
        .i_desc_src_stride (i_desc_src_stride),
        .i_desc_dst_stride (i_desc_dst_stride),
        .i_desc_irq        (i_desc_irq),
        .o_rd_start        (o_rd_start),
        .o_wr_start        (o_wr_start),
        .o_rd_src_addr     (o_rd_src_addr),
        .o_rd_width        (o_rd_width),
        .o_rd_height       (o_rd_height),
        .o_rd_stride       (o_rd_stride),
        .o_wr_dst_addr     (o_wr_dst_addr),
        .o_wr_width        (o_wr_width),
        .o_wr_height       (o_wr_height),
        .o_wr_stride       (o_wr_stride),
        .i_rd_done         (i_rd_done),
        .i_wr_done         (i_wr_done),
        .o_busy            (o_busy),
        .o_fifo_level      (o_fifo_level),
        .o_done_count      (o_done_count),
        .o_irq             (o_irq),
        .i_irq_clr         (i_irq_clr),
        .o_error           (o_error),
        .i_err_clr         (i_err_clr)
    );

    // Master model: done drops after the start cycle and rises `delay` cycles later, then stays high.
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            i_rd_done = 1'b0;
            i_wr_done = 1'b0;
            rd_timer  = 0;
            wr_timer  = 0;
        end else begin
            if (o_rd_start === 1'b1) begin
                i_rd_done = 1'b0;
                rd_timer  = rd_delay;
            end else if (rd_timer > 0) begin
                rd_timer--;
                if (rd_timer == 0 && !rd_hold) i_rd_done = 1'b1;
            end
            if (o_wr_start === 1'b1) begin
                i_wr_done = 1'b0;
                wr_timer  = wr_delay;
            end else if (wr_timer > 0) begin
                wr_timer--;
                if (wr_timer == 0) i_wr_done = 1'b1;
            end
        end
    end

    // Scoreboard: every start pulse must match the oldest accepted valid descriptor.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (o_rd_start !== 1'b0 || o_wr_start !== 1'b0)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL start_unexpected rd=%b wr=%b required no start", o_rd_start, o_wr_start);
            end else begin
                mon_e = sb_q.pop_front();
                if ({o_rd_start, o_wr_start, o_rd_src_addr, o_rd_width, o_rd_height, o_rd_stride,
                     o_wr_dst_addr, o_wr_width, o_wr_height, o_wr_stride} !==
                    {2'b11, mon_e.src, mon_e.w, mon_e.h, mon_e.ss, mon_e.dst, mon_e.w, mon_e.h, mon_e.ds}) begin
                    n_err++;
                    $display("FAIL start_params got st=%b%b rd=%h/%0d/%0d/%0d wr=%h/%0d/%0d/%0d req rd=%h/%0d/%0d/%0d wr=%h/%0d/%0d/%0d",
                             o_rd_start, o_wr_start, o_rd_src_addr, o_rd_width, o_rd_height, o_rd_stride,
                             o_wr_dst_addr, o_wr_width, o_wr_height, o_wr_stride,
                             mon_e.src, mon_e.w, mon_e.h, mon_e.ss, mon_e.dst, mon_e.w, mon_e.h, mon_e.ds);
                end
            end
        end
    end

    function automatic tdesc_t mk(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] w,
                                  input logic [31:0] h, input logic [31:0] ss, input logic [31:0] ds,
                                  input logic irq);
        tdesc_t d;
        d.src = src; d.dst = dst; d.w = w; d.h = h; d.ss = ss; d.ds = ds; d.irq = irq;
        return d;
    endfunction

    // Called just after a falling edge; returns one falling edge later with valid dropped.
    task automatic push_desc(input tdesc_t d, output bit acc);
        i_desc_valid      = 1'b1;
        i_desc_src_addr   = d.src;
        i_desc_dst_addr   = d.dst;
        i_desc_width      = d.w;
        i_desc_height     = d.h;
        i_desc_src_stride = d.ss;
        i_desc_dst_stride = d.ds;
        i_desc_irq        = d.irq;
        acc = (o_desc_ready === 1'b1);
        if (acc && d.w != 32'd0 && d.h != 32'd0 && d.w[1:0] == 2'b00) sb_q.push_back(d);
        @(negedge clk);
        i_desc_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        i_desc_valid = 1'b0;
        i_enable     = 1'b0;
        i_irq_clr    = 1'b0;
        i_err_clr    = 1'b0;
        rd_hold      = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.delete();
        exp_cnt = '0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        for (int k = 0; k < 40 && o_rd_start !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if (o_rd_start !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start_timeout got o_rd_start=%b required 1 within 40 cycles", tag, o_rd_start);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({o_desc_ready, o_rd_start, o_wr_start, o_busy, o_irq, o_error} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_flags got rdy/rs/ws/busy/irq/err=%b required 100000",
                     {o_desc_ready, o_rd_start, o_wr_start, o_busy, o_irq, o_error});
        end
        n_cmp++;
        if (o_fifo_level !== 3'd0 || o_done_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counts got level=%0d count=%0d required 0/0", o_fifo_level, o_done_count);
        end
        n_cmp++;
        if ({o_rd_src_addr, o_rd_width, o_rd_height, o_rd_stride,
             o_wr_dst_addr, o_wr_width, o_wr_height, o_wr_stride} !== 256'd0) begin
            n_err++;
            $display("FAIL reset_params got rd=%h/%0d wr=%h/%0d required zero", o_rd_src_addr, o_rd_width,
                     o_wr_dst_addr, o_wr_width);
        end
        apply_reset();
    endtask

    task automatic test_single();
        tdesc_t d;
        bit     acc;
        i_enable = 1'b1;
        rd_delay = 100;
        wr_delay = 100;
        d = mk(32'h1000, 32'h8000, 32'd64, 32'd4, 32'd256, 32'd64, 1'b1);
        push_desc(d, acc);
        n_cmp++;
        if (o_rd_start !== 1'b0) begin
            n_err++; $display("FAIL single_start_t0 got %b required 0", o_rd_start);
        end
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_err++; $display("FAIL single_busy_load got %b required 1", o_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (o_rd_start !== 1'b0 || o_rd_src_addr !== 32'h1000 || o_wr_dst_addr !== 32'h8000 ||
            o_rd_stride !== 32'd256 || o_wr_stride !== 32'd64) begin
            n_err++;
            $display("FAIL single_params_early got st=%b src=%h dst=%h ss=%0d ds=%0d required 0/1000/8000/256/64",
                     o_rd_start, o_rd_src_addr, o_wr_dst_addr, o_rd_stride, o_wr_stride);
        end
        @(negedge clk);
        n_cmp++;
        if (o_rd_start !== 1'b1 || o_wr_start !== 1'b1) begin
            n_err++; $display("FAIL single_start_t3 got %b%b required 11", o_rd_start, o_wr_start);
        end
        repeat (102) @(negedge clk);
        n_cmp++;
        if (o_done_count !== exp_cnt || o_irq !== 1'b0) begin
            n_err++;
            $display("FAIL single_count_early got count=%0d irq=%b required %0d/0", o_done_count, o_irq, exp_cnt);
        end
        @(negedge clk);
        exp_cnt++;
        n_cmp++;
        if (o_done_count !== exp_cnt || o_irq !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_complete got count=%0d irq=%b busy=%b required %0d/1/0",
                     o_done_count, o_irq, o_busy, exp_cnt);
        end
        i_irq_clr = 1'b1;
        @(negedge clk);
        i_irq_clr = 1'b0;
        n_cmp++;
        if (o_irq !== 1'b0) begin
            n_err++; $display("FAIL single_irq_clr got %b required 0", o_irq);
        end
    endtask

    task automatic test_fill();
        bit acc;
        i_enable = 1'b0;
        rd_delay = 5;
        wr_delay = 7;
        for (int k = 0; k < 4; k++) begin
            push_desc(mk(32'h2000 + 32'(k) * 32'h100, 32'h9000 + 32'(k) * 32'h40, 32'd16 * 32'(k + 1),
                         32'(k + 2), 32'd512, 32'd128, 1'b0), acc);
            n_cmp++;
            if (acc !== 1'b1) begin
                n_err++; $display("FAIL fill_accept%0d got ready=%b required 1", k, acc);
            end
        end
        n_cmp++;
        if (o_desc_ready !== 1'b0 || o_fifo_level !== 3'd4) begin
            n_err++;
            $display("FAIL fill_full got ready=%b level=%0d required 0/4", o_desc_ready, o_fifo_level);
        end
        push_desc(mk(32'hdead0000, 32'hbeef0000, 32'd8, 32'd1, 32'd8, 32'd8, 1'b1), acc);
        n_cmp++;
        if (o_fifo_level !== 3'd4 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL fill_refused got level=%0d busy=%b required 4/0", o_fifo_level, o_busy);
        end
        i_enable = 1'b1;
        exp_cnt  = exp_cnt + 16'd4;
        for (int k = 0; k < 400 && o_done_count !== exp_cnt; k++) @(negedge clk);
        n_cmp++;
        if (o_done_count !== exp_cnt || o_fifo_level !== 3'd0 || o_irq !== 1'b0) begin
            n_err++;
            $display("FAIL fill_drain got count=%0d level=%0d irq=%b required %0d/0/0",
                     o_done_count, o_fifo_level, o_irq, exp_cnt);
        end
    endtask

    task automatic test_invalid();
        tdesc_t d;
        bit     acc;
        i_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       d = mk(32'h3000, 32'h4000, 32'd6,  32'd4, 32'd64, 32'd64, 1'b0);
                1:       d = mk(32'h3100, 32'h4100, 32'd0,  32'd5, 32'd64, 32'd64, 1'b0);
                default: d = mk(32'h3200, 32'h4200, 32'd64, 32'd0, 32'd64, 32'd64, 1'b0);
            endcase
            push_desc(d, acc);
            repeat (2) @(negedge clk);
            n_cmp++;
            if (o_done_count !== exp_cnt) begin
                n_err++; $display("FAIL invalid%0d_early got count=%0d required %0d", k, o_done_count, exp_cnt);
            end
            @(negedge clk);
            exp_cnt++;
            n_cmp++;
            if (o_done_count !== exp_cnt || o_rd_width !== d.w || o_wr_height !== d.h || o_irq !== 1'b0) begin
                n_err++;
                $display("FAIL invalid%0d_done got count=%0d w=%0d h=%0d irq=%b required %0d/%0d/%0d/0",
                         k, o_done_count, o_rd_width, o_wr_height, o_irq, exp_cnt, d.w, d.h);
            end
        end
    endtask

    task automatic test_skew();
        bit acc;
        rd_delay = 10;
        wr_delay = 60;
        push_desc(mk(32'h5000, 32'h6000, 32'd128, 32'd3, 32'd256, 32'd128, 1'b0), acc);
        wait_start("skew");
        repeat (62) @(negedge clk);
        n_cmp++;
        if (o_done_count !== exp_cnt || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL skew_before_wr got count=%0d busy=%b required %0d/1", o_done_count, o_busy, exp_cnt);
        end
        @(negedge clk);
        exp_cnt++;
        n_cmp++;
        if (o_done_count !== exp_cnt) begin
            n_err++; $display("FAIL skew_after_wr got count=%0d required %0d", o_done_count, exp_cnt);
        end
    endtask

    task automatic test_irq_clr();
        bit acc;
        rd_delay = 5;
        wr_delay = 5;
        push_desc(mk(32'h7000, 32'h7800, 32'd32, 32'd2, 32'd32, 32'd32, 1'b1), acc);
        wait_start("irqclr");
        repeat (7) @(negedge clk);
        n_cmp++;
        if (o_irq !== 1'b0) begin
            n_err++; $display("FAIL irqclr_pre got %b required 0", o_irq);
        end
        i_irq_clr = 1'b1;
        @(negedge clk);
        exp_cnt++;
        n_cmp++;
        if (o_irq !== 1'b1 || o_done_count !== exp_cnt) begin
            n_err++;
            $display("FAIL irqclr_set_wins got irq=%b count=%0d required 1/%0d", o_irq, o_done_count, exp_cnt);
        end
        @(negedge clk);
        i_irq_clr = 1'b0;
        n_cmp++;
        if (o_irq !== 1'b0) begin
            n_err++; $display("FAIL irqclr_next got %b required 0", o_irq);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int gap;
        i_enable = 1'b0;
        rd_delay = 5;
        wr_delay = 5;
        push_desc(mk(32'ha000, 32'hb000, 32'd4, 32'd1, 32'd4, 32'd4, 1'b0), acc);
        push_desc(mk(32'ha100, 32'hb100, 32'd8, 32'd2, 32'd16, 32'd16, 1'b0), acc);
        i_enable = 1'b1;
        for (int k = 0; k < 60 && o_done_count !== exp_cnt + 16'd1; k++) @(negedge clk);
        n_cmp++;
        if (o_done_count !== exp_cnt + 16'd1) begin
            n_err++;
            $display("FAIL b2b_first got count=%0d required %0d", o_done_count, exp_cnt + 16'd1);
        end
        gap = 0;
        while (o_rd_start !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        n_cmp++;
        if (gap != 3) begin
            n_err++; $display("FAIL b2b_gap got %0d cycles required 3", gap);
        end
        exp_cnt = exp_cnt + 16'd2;
        for (int k = 0; k < 60 && o_done_count !== exp_cnt; k++) @(negedge clk);
        n_cmp++;
        if (o_done_count !== exp_cnt || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_second got count=%0d pending=%0d required %0d/0", o_done_count, sb_q.size(), exp_cnt);
        end
    endtask

    task automatic test_timeout();
        bit acc;
        rd_delay = 5;
        wr_delay = 5;
        rd_hold  = 1'b1;
        i_enable = 1'b1;
        push_desc(mk(32'hc000, 32'hd000, 32'd16, 32'd2, 32'd16, 32'd16, 1'b0), acc);
`ifdef DMA_SCHED_TIMEOUT_EN
        push_desc(mk(32'hc100, 32'hd100, 32'd16, 32'd2, 32'd16, 32'd16, 1'b0), acc);
        for (int k = 0; k < 40 && o_rd_start !== 1'b1; k++) @(negedge clk);
        repeat (254) @(negedge clk);
        n_cmp++;
        if (o_error !== 1'b0) begin
            n_err++; $display("FAIL timeout_early got %b required 0", o_error);
        end
        @(negedge clk);
        n_cmp++;
        if (o_error !== 1'b1 || o_busy !== 1'b1 || o_fifo_level !== 3'd1) begin
            n_err++;
            $display("FAIL timeout_fire got err=%b busy=%b level=%0d required 1/1/1", o_error, o_busy, o_fifo_level);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (o_error !== 1'b1 || o_fifo_level !== 3'd1) begin
            n_err++;
            $display("FAIL timeout_hold got err=%b level=%0d required 1/1", o_error, o_fifo_level);
        end
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        void'(sb_q.pop_back());
        rd_hold = 1'b0;
        n_cmp++;
        if (o_error !== 1'b0 || o_fifo_level !== 3'd0 || o_busy !== 1'b0 || o_done_count !== exp_cnt) begin
            n_err++;
            $display("FAIL timeout_clear got err=%b level=%0d busy=%b count=%0d required 0/0/0/%0d",
                     o_error, o_fifo_level, o_busy, o_done_count, exp_cnt);
        end
        repeat (10) @(negedge clk);
`else
        wait_start("nowd");
        repeat (300) @(negedge clk);
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        n_cmp++;
        if (o_error !== 1'b0 || o_busy !== 1'b1 || o_done_count !== exp_cnt) begin
            n_err++;
            $display("FAIL nowd_stuck got err=%b busy=%b count=%0d required 0/1/%0d",
                     o_error, o_busy, o_done_count, exp_cnt);
        end
        apply_reset();
`endif
    endtask

    task automatic test_reset_mid();
        bit acc;
        i_enable = 1'b1;
        rd_delay = 5;
        wr_delay = 5;
        for (int k = 0; k < 3; k++)
            push_desc(mk(32'he000 + 32'(k), 32'hf000, 32'd12, 32'd1, 32'd12, 32'd12, 1'b1), acc);
        for (int k = 0; k < 60 && o_done_count !== exp_cnt + 16'd1; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_fifo_level !== 3'd0 || o_done_count !== 16'd0 || o_irq !== 1'b0 ||
            o_desc_ready !== 1'b1 || o_rd_src_addr !== 32'd0 || o_rd_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got busy=%b level=%0d count=%0d irq=%b rdy=%b src=%h st=%b required 0/0/0/0/1/0/0",
                     o_busy, o_fifo_level, o_done_count, o_irq, o_desc_ready, o_rd_src_addr, o_rd_start);
        end
        apply_reset();
        i_enable = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_done_count !== exp_cnt) begin
            n_err++;
            $display("FAIL reset_mid_after got busy=%b count=%0d required 0/%0d", o_busy, o_done_count, exp_cnt);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        i_enable          = 1'b0;
        i_desc_valid      = 1'b0;
        i_desc_src_addr   = '0;
        i_desc_dst_addr   = '0;
        i_desc_width      = '0;
        i_desc_height     = '0;
        i_desc_src_stride = '0;
        i_desc_dst_stride = '0;
        i_desc_irq        = 1'b0;
        i_irq_clr         = 1'b0;
        i_err_clr         = 1'b0;
        i_rd_done         = 1'b0;
        i_wr_done         = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_invalid();
        test_skew();
        test_irq_clr();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation exceeded 40000 cycles");
        $fatal(1);
    end

endmodule

// File: doc/dma_2d_desc_sched.md
# dma_2d_desc_sched

Descriptor-queue scheduler sequencing the 2D read master and 2D write master of the DMA core. Software pushes crop/copy descriptors into a small internal FIFO. The block pops one at a time, drives the parameters of both masters, and pulses their starts together. It waits for both completion flags, then counts the completion and optionally raises an interrupt before launching the next descriptor.

## Interface
- DESC_DEPTH, 4, descriptor FIFO depth; power of two, ≥2
- CNT_W, 16, width of completion counter
- TIMEOUT_W, 24, watchdog counter width (used only with DMA_SCHED_TIMEOUT_EN)

Clock and reset are fixed: one clock; reset is asynchronous and active-low.

- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  allow popping new descriptors
- i_desc_valid  in  1  descriptor push request
- o_desc_ready  out  1  FIFO not full
- i_desc_src_addr, i_desc_dst_addr  in  32 each  start addresses
- i_desc_width  in  32  bytes per row
- i_desc_height  in  32  rows
- i_desc_src_stride, i_desc_dst_stride  in  32 each  row pitch, bytes
- i_desc_irq  in  1  raise o_irq when this descriptor completes
- o_rd_start, o_wr_start  out  1  one-cycle start pulses
- o_rd_src_addr, o_rd_width, o_rd_height, o_rd_stride  out  32 each  read-master parameters
- o_wr_dst_addr, o_wr_width, o_wr_height, o_wr_stride  out  32 each  write-master parameters
- i_rd_done, i_wr_done  in  1  master done flags; sticky-high, drop the cycle after start
- o_busy  out  1  descriptor in flight (state ≠ IDLE)
- o_fifo_level  out  $clog2(DESC_DEPTH)+1  queued descriptor count
- o_done_count  out  CNT_W  completed descriptors, wraps
- o_irq  out  1  level interrupt
- i_irq_clr  in  1  clears o_irq
- o_error  out  1  watchdog fired
- i_err_clr  in  1  clears the error and flushes the FIFO

## Operation
- Push:
  - Accepted when i_desc_valid && o_desc_ready; o_desc_ready = (level < DESC_DEPTH).
  - A simultaneous push and pop leaves the level unchanged; a push when full is refused.
- FSM states: IDLE, LOAD, START, WAIT, COMPLETE, ERROR.
- IDLE → LOAD when i_enable && level>0; the FIFO is popped on this transition.
- LOAD registers the popped entry into all o_rd_*/o_wr_* outputs, which hold until the next LOAD.
  - Invalid descriptor (width==0, height==0, or width[1:0]≠0): go to COMPLETE directly; no start pulses, still counted.
  - Otherwise go to START.
- START: assert o_rd_start and o_wr_start for exactly one cycle; clear the done latches and the watchdog; go to WAIT.
- WAIT:
  - Per master, a rising-edge detector runs on done (prev register updated every cycle).
  - An edge sets that master's latch; edges outside WAIT are ignored.
  - When both latches are set, go to COMPLETE. Simultaneous edges are legal.
- COMPLETE: o_done_count += 1 (modulo 2^CNT_W); o_irq set if the entry's irq bit is set; go to IDLE.
- o_irq: set wins over i_irq_clr in the same cycle.
- i_enable deassert: the in-flight descriptor finishes; no new pop.
- Reset mid-operation: all state and the FIFO cleared immediately. The masters are reset by the same reset_n.

## Timing
- Reset values: o_desc_ready=1, all start pulses 0, all parameter outputs 0, o_busy=0, o_fifo_level=0, o_done_count=0, o_irq=0, o_error=0.
- Push into an empty FIFO at edge T0, with the FSM idle and enabled:
  - IDLE→LOAD at T1.
  - Parameters valid after T2.
  - o_*_start high during the cycle after T3.
- Parameters are stable ≥1 cycle before the start pulse.
- Completion: the last done edge is sampled at edge E, COMPLETE follows at E+1, and o_done_count/o_irq update at E+2.
- Back-to-back descriptors: 4 cycles from COMPLETE to the next start pulse.

## Configuration
- DMA_SCHED_TIMEOUT_EN defined:
  - In WAIT, a TIMEOUT_W-bit counter increments each cycle.
  - At all-ones it enters ERROR: o_error=1, o_busy=1, no pops.
  - i_err_clr flushes the FIFO (level→0), clears o_error and returns to IDLE.
- DMA_SCHED_TIMEOUT_EN undefined: no counter, no ERROR state; o_error tied 0; i_err_clr ignored.

## Test plan
- Push one descriptor (src 0x1000, dst 0x8000, width 64, height 4, strides 256/64, irq=1); model done 100 cycles after start:
  - Start pulses 3 cycles after the push, outputs match.
  - o_done_count=1 and o_irq=1 two cycles after the done edge.
- Fill the FIFO with 4 pushes while i_enable=0: o_desc_ready=0 and the 5th push is refused. Set i_enable=1: four sequential transfers, o_done_count=4.
- Descriptor with width 6: no start pulse; o_done_count increments 2 cycles after LOAD.
- i_wr_done rises 50 cycles after i_rd_done: COMPLETE only after the write edge. Stale high done before start is not counted.
- i_irq_clr asserted in the same cycle o_irq is set: o_irq=1. Clear on the next cycle: o_irq=0.
- With DMA_SCHED_TIMEOUT_EN and TIMEOUT_W=8, withhold i_rd_done:
  - o_error=1 after 255 WAIT cycles.
  - i_err_clr flushes the FIFO (level 0) and returns to IDLE.
